pattern_gen: RTL and testbench

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_pkg.sv | 28 ++
 rtl/pattern_gen_if.sv | 30 +++
 rtl/pattern_xy_cnt.sv | 67 ++++++
 rtl/pattern_gen.sv | 141 ++++++++++++++
 tb/tb_pattern_gen.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_pkg.sv
// Shared constants, request-FSM state type and bar-level helper for the pattern generator.
package pattern_pkg;

   localparam logic [1:0] PAT_BORDER = 2'd0;
   localparam logic [1:0] PAT_BARS   = 2'd1;
   localparam logic [1:0] PAT_GRID   = 2'd2;
   localparam logic [1:0] PAT_AUX    = 2'd3;

   localparam logic [8:0] BAR_W    = 9'd40;
   localparam logic [7:0] BAR_STEP = 8'd36;
   localparam logic [8:0] ACT_W    = 9'd320;
   localparam logic [7:0] ACT_H    = 8'd240;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } req_state_e;

   // Bar index is x/BAR_W clamped to the last bar, then scaled to a luma step.
   function automatic logic [7:0] bar_level(input logic [8:0] x);
      logic [8:0] quot;
      logic [7:0] idx;
      quot = x / BAR_W;
      idx  = (quot > 9'd7) ? 8'd7 : {5'd0, quot[2:0]};
      return idx * BAR_STEP;
   endfunction

endpackage

// File: rtl/pattern_gen_if.sv
// Timing-in / video-out bundle of the pattern generator; slave is the generator side.
interface pattern_gen_if;

   logic       ce_pix;
   logic       hblank_in;
   logic       vblank_in;
   logic       hsync_in;
   logic       vsync_in;
   logic [1:0] pat_sel;
   logic       pat_req;
   logic       ce_pix_out;
   logic       HBlank;
   logic       VBlank;
   logic       HSync;
   logic       VSync;
   logic [7:0] video;
   logic [1:0] pat_active;
   logic       pat_pending;

   modport slave (
      input  ce_pix, hblank_in, vblank_in, hsync_in, vsync_in, pat_sel, pat_req,
      output ce_pix_out, HBlank, VBlank, HSync, VSync, video, pat_active, pat_pending
   );

   modport master (
      output ce_pix, hblank_in, vblank_in, hsync_in, vsync_in, pat_sel, pat_req,
      input  ce_pix_out, HBlank, VBlank, HSync, VSync, video, pat_active, pat_pending
   );

endinterface

// File: rtl/pattern_xy_cnt.sv
// Pixel/line counters with blanking edge detection; x/y are the values before this edge's update.
module pattern_xy_cnt (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce_pix,
   input  logic       hblank_in,
   input  logic       vblank_in,
   output logic [8:0] x,
   output logic [7:0] y,
   output logic       frame_edge
);

   logic [8:0] x_q, x_d;
   logic [7:0] y_q, y_d;
   logic       hb_prev_q, hb_prev_d;
   logic       vb_prev_q, vb_prev_d;

   // Counter next-state; everything holds when the pixel enable is low.
   always_comb begin
      x_d       = x_q;
      y_d       = y_q;
      hb_prev_d = hb_prev_q;
      vb_prev_d = vb_prev_q;
      if (ce_pix) begin
         hb_prev_d = hblank_in;
         vb_prev_d = vblank_in;
         if (hblank_in) begin
            x_d = 9'd0;
         end else if (x_q != 9'h1FF) begin
            x_d = x_q + 9'd1;
         end else begin
            x_d = x_q;
         end
         // A new line starts on the rising edge of hblank outside vblank.
         if (vblank_in) begin
            y_d = 8'd0;
         end else if (hblank_in && !hb_prev_q && (y_q != 8'hFF)) begin
            y_d = y_q + 8'd1;
         end else begin
            y_d = y_q;
         end
      end else begin
         x_d = x_q;
         y_d = y_q;
      end
   end

   // Counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         x_q       <= 9'd0;
         y_q       <= 8'd0;
         hb_prev_q <= 1'b0;
         vb_prev_q <= 1'b0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         hb_prev_q <= hb_prev_d;
         vb_prev_q <= vb_prev_d;
      end
   end

   assign x          = x_q;
   assign y          = y_q;
   assign frame_edge = ce_pix & vblank_in & ~vb_prev_q;

endmodule

// File: rtl/pattern_gen.sv
// Test-pattern video generator with frame-synchronous pattern switching.
// Define PATTERN_CHECKER_EN to make pattern 3 a checkerboard instead of flat grey.
module pattern_gen
   import pattern_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   pattern_gen_if.slave  bus
);

   logic [8:0] x_s;
   logic [7:0] y_s;
   logic       frame_edge_s;
   logic [7:0] pat_video_s;

   req_state_e state_q, state_d;
   logic [1:0] pending_q, pending_d;
   logic [1:0] active_q, active_d;
   logic       pat_pending_q, pat_pending_d;
   logic       ce_out_q;
   logic       hblank_q, hblank_d;
   logic       vblank_q, vblank_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic [7:0] video_q, video_d;

   pattern_xy_cnt u_xy_cnt (
      .clk        (clk),
      .reset      (reset),
      .ce_pix     (bus.ce_pix),
      .hblank_in  (bus.hblank_in),
      .vblank_in  (bus.vblank_in),
      .x          (x_s),
      .y          (y_s),
      .frame_edge (frame_edge_s)
   );

   // Pattern luma for the current pixel position.
   always_comb begin
      pat_video_s = 8'd0;
      case (active_q)
         PAT_BORDER: begin
            if ((x_s == 9'd0) || (x_s == ACT_W - 9'd1) ||
                (y_s == 8'd0) || (y_s == ACT_H - 8'd1)) begin
               pat_video_s = 8'd255;
            end else begin
               pat_video_s = 8'd0;
            end
         end
         PAT_BARS: pat_video_s = bar_level(x_s);
         PAT_GRID: begin
            if ((x_s[3:0] == 4'd0) || (y_s[3:0] == 4'd0)) begin
               pat_video_s = 8'd255;
            end else begin
               pat_video_s = 8'd0;
            end
         end
`ifdef PATTERN_CHECKER_EN
         PAT_AUX: pat_video_s = (x_s[3] ^ y_s[3]) ? 8'd255 : 8'd0;
`else
         PAT_AUX: pat_video_s = 8'd128;
`endif
         default: pat_video_s = 8'd0;
      endcase
   end

   // Video/timing next-state plus request FSM next-state.
   always_comb begin
      video_d   = video_q;
      hblank_d  = hblank_q;
      vblank_d  = vblank_q;
      hsync_d   = hsync_q;
      vsync_d   = vsync_q;
      state_d   = state_q;
      pending_d = pending_q;
      active_d  = active_q;
      if (bus.ce_pix) begin
         video_d  = (bus.hblank_in || bus.vblank_in) ? 8'd0 : pat_video_s;
         hblank_d = bus.hblank_in;
         vblank_d = bus.vblank_in;
         hsync_d  = bus.hsync_in;
         vsync_d  = bus.vsync_in;
      end else begin
         video_d  = video_q;
      end
      // A request landing on the boundary itself bypasses the pending register.
      if (frame_edge_s) begin
         if (bus.pat_req) begin
            active_d = bus.pat_sel;
         end else if (state_q == ST_PENDING) begin
            active_d = pending_q;
         end else begin
            active_d = active_q;
         end
         state_d = ST_IDLE;
      end else if (bus.pat_req) begin
         pending_d = bus.pat_sel;
         state_d   = ST_PENDING;
      end else begin
         state_d = state_q;
      end
      pat_pending_d = (state_d == ST_PENDING);
   end

   // All registers, including the request FSM, with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         pending_q     <= 2'd0;
         active_q      <= PAT_BORDER;
         pat_pending_q <= 1'b0;
         ce_out_q      <= 1'b0;
         hblank_q      <= 1'b0;
         vblank_q      <= 1'b0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         video_q       <= 8'd0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         active_q      <= active_d;
         pat_pending_q <= pat_pending_d;
         ce_out_q      <= bus.ce_pix;
         hblank_q      <= hblank_d;
         vblank_q      <= vblank_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_q       <= video_d;
      end
   end

   assign bus.ce_pix_out  = ce_out_q;
   assign bus.HBlank      = hblank_q;
   assign bus.VBlank      = vblank_q;
   assign bus.HSync       = hsync_q;
   assign bus.VSync       = vsync_q;
   assign bus.video       = video_q;
   assign bus.pat_active  = active_q;
   assign bus.pat_pending = pat_pending_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: reset, patterns, deferred/last-wins/coincident switching, alignment.
module tb_pattern_gen;

   logic clk = 1'b0;
   logic reset;
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   logic [7:0] line_buf [0:539];

   pattern_gen_if bus();

   pattern_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // One line: len active pixels then 4 hblank pixels; line_buf[i] holds the video for pixel i.
   task automatic run_line(input int len);
      for (int i = 0; i < len; i++) begin
         bus.hblank_in = 1'b0;
         bus.vblank_in = 1'b0;
         step();
         line_buf[i] = bus.video;
      end
      for (int i = len; i < len + 4; i++) begin
         bus.hblank_in = 1'b1;
         step();
         line_buf[i] = bus.video;
      end
   endtask

   task automatic run_lines(input int n);
      for (int i = 0; i < n; i++) run_line(320);
   endtask

   task automatic vblank(input int n);
      bus.hblank_in = 1'b1;
      bus.vblank_in = 1'b1;
      for (int i = 0; i < n; i++) step();
   endtask

   // Request strobe issued on a ce_pix=0 clock so the counters do not move.
   task automatic request(input logic [1:0] sel);
      bus.ce_pix  = 1'b0;
      bus.pat_req = 1'b1;
      bus.pat_sel = sel;
      step();
      bus.pat_req = 1'b0;
      bus.ce_pix  = 1'b1;
   endtask

   initial begin
      reset         = 1'b0;
      bus.ce_pix    = 1'b1;
      bus.hblank_in = 1'b1;
      bus.vblank_in = 1'b1;
      bus.hsync_in  = 1'b1;
      bus.vsync_in  = 1'b1;
      bus.pat_sel   = 2'd3;
      bus.pat_req   = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("rst_video",   {1'b0, bus.video}, 9'd0);
      chk("rst_hblank",  {8'd0, bus.HBlank}, 9'd0);
      chk("rst_vblank",  {8'd0, bus.VBlank}, 9'd0);
      chk("rst_hsync",   {8'd0, bus.HSync}, 9'd0);
      chk("rst_vsync",   {8'd0, bus.VSync}, 9'd0);
      chk("rst_ce_out",  {8'd0, bus.ce_pix_out}, 9'd0);
      chk("rst_active",  {7'd0, bus.pat_active}, 9'd0);
      chk("rst_pending", {8'd0, bus.pat_pending}, 9'd0);

      bus.hsync_in = 1'b0;
      bus.vsync_in = 1'b0;
      bus.pat_req  = 1'b0;
      reset        = 1'b1;
      vblank(3);
      chk("rel_active",  {7'd0, bus.pat_active}, 9'd0);
      chk("rel_pending", {8'd0, bus.pat_pending}, 9'd0);
      chk("rel_vblank",  {8'd0, bus.VBlank}, 9'd1);

      // Output timing follows input by exactly one clock and holds while ce_pix=0.
      chk("hs_before", {8'd0, bus.HSync}, 9'd0);
      bus.hsync_in = 1'b1;
      step();
      chk("hs_rise", {8'd0, bus.HSync}, 9'd1);
      bus.ce_pix   = 1'b0;
      bus.hsync_in = 1'b0;
      step();
      chk("hs_hold_noce", {8'd0, bus.HSync}, 9'd1);
      chk("ce_out_low",   {8'd0, bus.ce_pix_out}, 9'd0);
      bus.ce_pix = 1'b1;
      step();
      chk("hs_fall",     {8'd0, bus.HSync}, 9'd0);
      chk("ce_out_high", {8'd0, bus.ce_pix_out}, 9'd1);

      // Border frame.
      run_line(320);
      chk("brd_y0_x100", {1'b0, line_buf[100]}, 9'd255);
      chk("brd_hblank",  {1'b0, line_buf[321]}, 9'd0);
      run_line(320);
      chk("brd_y1_x0",   {1'b0, line_buf[0]}, 9'd255);
      chk("brd_y1_x1",   {1'b0, line_buf[1]}, 9'd0);
      chk("brd_y1_x318", {1'b0, line_buf[318]}, 9'd0);
      chk("brd_y1_x319", {1'b0, line_buf[319]}, 9'd255);
      chk("hb_out_high", {8'd0, bus.HBlank}, 9'd1);

      request(2'd1);
      chk("req1_pending", {8'd0, bus.pat_pending}, 9'd1);
      chk("req1_active",  {7'd0, bus.pat_active}, 9'd0);
      run_line(320);
      chk("defer_x319", {1'b0, line_buf[319]}, 9'd255);
      chk("defer_x5",   {1'b0, line_buf[5]}, 9'd0);
      chk("vb_before",  {8'd0, bus.VBlank}, 9'd0);
      vblank(1);
      chk("vb_rise",      {8'd0, bus.VBlank}, 9'd1);
      chk("sw1_active",   {7'd0, bus.pat_active}, 9'd1);
      chk("sw1_pending",  {8'd0, bus.pat_pending}, 9'd0);
      vblank(2);

      // Bars frame; line 10 is long to push x into saturation.
      run_lines(10);
      run_line(520);
      chk("bar_x0",   {1'b0, line_buf[0]}, 9'd0);
      chk("bar_x39",  {1'b0, line_buf[39]}, 9'd0);
      chk("bar_x40",  {1'b0, line_buf[40]}, 9'd36);
      chk("bar_x160", {1'b0, line_buf[160]}, 9'd144);
      chk("bar_x279", {1'b0, line_buf[279]}, 9'd216);
      chk("bar_x280", {1'b0, line_buf[280]}, 9'd252);
      chk("bar_x319", {1'b0, line_buf[319]}, 9'd252);
      chk("bar_x515", {1'b0, line_buf[515]}, 9'd252);
      chk("bar_hblank", {1'b0, line_buf[521]}, 9'd0);

      request(2'd2);
      chk("req2_pending", {8'd0, bus.pat_pending}, 9'd1);
      chk("req2_active",  {7'd0, bus.pat_active}, 9'd1);
      run_line(320);
      chk("defer_bar_x40", {1'b0, line_buf[40]}, 9'd36);
      vblank(1);
      chk("sw2_active",  {7'd0, bus.pat_active}, 9'd2);
      chk("sw2_pending", {8'd0, bus.pat_pending}, 9'd0);
      vblank(2);

      // Grid frame; line 5 is long to check x saturation at 511.
      run_line(320);
      chk("grid_y0_x7", {1'b0, line_buf[7]}, 9'd255);
      run_lines(4);
      run_line(520);
      chk("grid_y5_x0",   {1'b0, line_buf[0]}, 9'd255);
      chk("grid_y5_x15",  {1'b0, line_buf[15]}, 9'd0);
      chk("grid_y5_x16",  {1'b0, line_buf[16]}, 9'd255);
      chk("grid_y5_x17",  {1'b0, line_buf[17]}, 9'd0);
      chk("grid_y5_x496", {1'b0, line_buf[496]}, 9'd255);
      chk("grid_x511",    {1'b0, line_buf[511]}, 9'd0);
      chk("grid_xsat",    {1'b0, line_buf[512]}, 9'd0);
      chk("grid_xsat2",   {1'b0, line_buf[515]}, 9'd0);

      // Last request in a frame wins.
      request(2'd1);
      request(2'd2);
      chk("lw_pending", {8'd0, bus.pat_pending}, 9'd1);
      chk("lw_active",  {7'd0, bus.pat_active}, 9'd2);
      run_line(320);
      chk("lw_y6_x16", {1'b0, line_buf[16]}, 9'd255);
      chk("lw_y6_x17", {1'b0, line_buf[17]}, 9'd0);
      vblank(1);
      chk("lw_sw_active", {7'd0, bus.pat_active}, 9'd2);
      vblank(2);
      run_line(320);
      chk("lw_grid_x7", {1'b0, line_buf[7]}, 9'd255);

      // Request on the vblank-rise cycle applies immediately.
      bus.hblank_in = 1'b1;
      bus.vblank_in = 1'b1;
      bus.pat_req   = 1'b1;
      bus.pat_sel   = 2'd3;
      step();
      bus.pat_req = 1'b0;
      chk("co_active",  {7'd0, bus.pat_active}, 9'd3);
      chk("co_pending", {8'd0, bus.pat_pending}, 9'd0);
      vblank(2);

      run_line(320);
`ifdef PATTERN_CHECKER_EN
      chk("aux_y0_x8", {1'b0, line_buf[8]}, 9'd255);
      chk("aux_y0_x0", {1'b0, line_buf[0]}, 9'd0);
`else
      chk("aux_y0_x8", {1'b0, line_buf[8]}, 9'd128);
      chk("aux_y0_x0", {1'b0, line_buf[0]}, 9'd128);
`endif
      run_lines(7);
      run_line(320);
`ifdef PATTERN_CHECKER_EN
      chk("aux_y8_x8", {1'b0, line_buf[8]}, 9'd0);
      chk("aux_y8_x0", {1'b0, line_buf[0]}, 9'd255);
`else
      chk("aux_y8_x8", {1'b0, line_buf[8]}, 9'd128);
      chk("aux_y8_x0", {1'b0, line_buf[0]}, 9'd128);
`endif

      // Reset while pending discards the request.
      request(2'd1);
      chk("rp_pending", {8'd0, bus.pat_pending}, 9'd1);
      reset = 1'b0;
      step();
      step();
      chk("rp_rst_pending", {8'd0, bus.pat_pending}, 9'd0);
      chk("rp_rst_active",  {7'd0, bus.pat_active}, 9'd0);
      chk("rp_rst_video",   {1'b0, bus.video}, 9'd0);
      reset = 1'b1;
      run_line(320);
      chk("rp_y0_x0",   {1'b0, line_buf[0]}, 9'd255);
      chk("rp_y0_x150", {1'b0, line_buf[150]}, 9'd255);
      run_line(320);
      chk("rp_y1_x1",   {1'b0, line_buf[1]}, 9'd0);
      chk("rp_y1_x319", {1'b0, line_buf[319]}, 9'd255);
      vblank(1);
      chk("rp_edge_active",  {7'd0, bus.pat_active}, 9'd0);
      chk("rp_edge_pending", {8'd0, bus.pat_pending}, 9'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
